// File: rtl/aes_pkg.sv
// Shared AES datapath types and the column-major state byte indexing helper.
package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [7:0]   aes_byte_t;

    // Byte k of the state sits at row r, column c with k = r + 4c (byte 0 is the MSB).
    function automatic int byte_idx(input int r, input int c);
        return r + 4 * c;
    endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational AES ShiftRows (INVERSE=0) or InvShiftRows (INVERSE=1) byte permutation.
module shift_rows_perm
    import aes_pkg::*;
#(
    parameter bit INVERSE = 1'b0
) (
    input  aes_state_t in,
    output aes_state_t out
);

    // Pure wiring: each output byte (r,c) takes input byte (r, c+r) or (r, c-r) mod 4.
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            localparam int SRC_C = INVERSE ? ((c - r + 4) % 4) : ((c + r) % 4);
            localparam int DST_K = byte_idx(r, c);
            localparam int SRC_K = byte_idx(r, SRC_C);
            assign out[127 - 8 * DST_K -: 8] = in[127 - 8 * SRC_K -: 8];
        end
    end

endmodule

// File: rtl/shift_rows_unit.sv
// AES ShiftRows stage: independent forward and inverse lanes behind an optional
// output register with a valid flag.
module shift_rows_unit
    import aes_pkg::*;
#(
    parameter bit REGISTERED = 1'b1
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         in_valid,
    input  aes_state_t   fwd_in,
    input  aes_state_t   inv_in,
    output logic         out_valid,
    output aes_state_t   fwd_out,
    output aes_state_t   inv_out
);

    aes_state_t fwd_perm_s;
    aes_state_t inv_perm_s;

    shift_rows_perm #(.INVERSE(1'b0)) u_fwd_perm (
        .in  (fwd_in),
        .out (fwd_perm_s)
    );

    shift_rows_perm #(.INVERSE(1'b1)) u_inv_perm (
        .in  (inv_in),
        .out (inv_perm_s)
    );

    if (REGISTERED) begin : g_reg
        logic       out_valid_r;
        aes_state_t fwd_out_r;
        aes_state_t inv_out_r;

        // Output stage: data registers only load on in_valid and otherwise hold.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                out_valid_r <= 1'b0;
                fwd_out_r   <= '0;
                inv_out_r   <= '0;
            end else if (in_valid) begin
                out_valid_r <= 1'b1;
                fwd_out_r   <= fwd_perm_s;
                inv_out_r   <= inv_perm_s;
            end else begin
                out_valid_r <= 1'b0;
            end
        end

        assign out_valid = out_valid_r;
        assign fwd_out   = fwd_out_r;
        assign inv_out   = inv_out_r;
    end else begin : g_bypass
        logic unused_s;
        assign unused_s  = clock ^ reset_n;
        assign out_valid = in_valid;
        assign fwd_out   = fwd_perm_s;
        assign inv_out   = inv_perm_s;
    end

endmodule

// File: tb/tb_shift_rows_unit.sv
// Directed self-checking bench for shift_rows_unit (REGISTERED=1).
module tb_shift_rows_unit;

    logic         clock;
    logic         reset_n;
    logic         in_valid;
    logic [127:0] fwd_in;
    logic [127:0] inv_in;
    logic         out_valid;
    logic [127:0] fwd_out;
    logic [127:0] inv_out;

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [127:0] FIPS_IN   = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] FIPS_OUT  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] RAMP      = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] RAMP_FWD  = 128'h00050a0f04090e03080d02070c01060b;
    localparam logic [127:0] RAMP_INV  = 128'h000d0a0704010e0b0805020f0c090603;
    localparam logic [127:0] PAT_A5    = 128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5;

    shift_rows_unit #(.REGISTERED(1'b1)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .fwd_in    (fwd_in),
        .inv_in    (inv_in),
        .out_valid (out_valid),
        .fwd_out   (fwd_out),
        .inv_out   (inv_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference ShiftRows: row r of the state rotated left by r columns.
    function automatic logic [127:0] sr_model(input logic [127:0] x);
        logic [7:0]   st [4][4];
        logic [127:0] y;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                st[r][c] = x[127 - 8 * (r + 4 * c) -: 8];
        y = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                y[127 - 8 * (r + 4 * c) -: 8] = st[r][(c + r) % 4];
        return y;
    endfunction

    task automatic check_out(input string name, input logic ev,
                             input logic [127:0] ef, input logic [127:0] ei);
        tests_run++;
        if (out_valid !== ev || fwd_out !== ef || inv_out !== ei) begin
            tests_failed++;
            $display("FAIL %s: got v=%0b fwd=%h inv=%h, expected v=%0b fwd=%h inv=%h",
                     name, out_valid, fwd_out, inv_out, ev, ef, ei);
        end
    endtask

    task automatic drive(input logic v, input logic [127:0] f, input logic [127:0] i);
        in_valid = v;
        fwd_in   = f;
        inv_in   = i;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b1, FIPS_IN, FIPS_OUT);
        #1;
        check_out("reset_state", 1'b0, '0, '0);
        @(negedge clock);
        @(negedge clock);
        check_out("reset_held", 1'b0, '0, '0);
        reset_n = 1'b1;
        drive(1'b0, '0, '0);
        @(negedge clock);
        check_out("post_release_idle", 1'b0, '0, '0);
    endtask

    task automatic test_fips_fwd();
        drive(1'b1, FIPS_IN, RAMP_FWD);
        @(negedge clock);
        check_out("fips_fwd", 1'b1, FIPS_OUT, RAMP);
        drive(1'b0, '0, '0);
        @(negedge clock);
    endtask

    task automatic test_ramp();
        drive(1'b1, RAMP, RAMP);
        @(negedge clock);
        check_out("ramp", 1'b1, RAMP_FWD, RAMP_INV);
        drive(1'b0, '0, '0);
        @(negedge clock);
    endtask

    task automatic test_inv_fips();
        drive(1'b1, RAMP_INV, FIPS_OUT);
        @(negedge clock);
        check_out("fips_inv", 1'b1, RAMP, FIPS_IN);
        drive(1'b0, '0, '0);
        @(negedge clock);
    endtask

    task automatic test_round_trip();
        logic [127:0] x;
        logic [127:0] sx;
        for (int n = 0; n < 1000; n++) begin
            x  = {$urandom, $urandom, $urandom, $urandom};
            sx = sr_model(x);
            drive(1'b1, x, sx);
            @(negedge clock);
            tests_run++;
            if (inv_out !== x || fwd_out !== sx || out_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL round_trip[%0d]: got v=%0b fwd=%h inv=%h, expected v=1 fwd=%h inv=%h",
                         n, out_valid, fwd_out, inv_out, sx, x);
            end
        end
        drive(1'b0, '0, '0);
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        drive(1'b1, FIPS_IN, FIPS_OUT);
        @(negedge clock);
        check_out("stream_0", 1'b1, FIPS_OUT, FIPS_IN);
        drive(1'b1, RAMP, RAMP);
        @(negedge clock);
        check_out("stream_1", 1'b1, RAMP_FWD, RAMP_INV);
        drive(1'b1, RAMP_INV, RAMP_FWD);
        @(negedge clock);
        check_out("stream_2", 1'b1, RAMP, RAMP);
        drive(1'b1, PAT_A5, PAT_A5);
        @(negedge clock);
        check_out("stream_3", 1'b1, PAT_A5, PAT_A5);
        drive(1'b0, FIPS_IN, FIPS_IN);
        @(negedge clock);
        check_out("stream_idle_hold", 1'b0, PAT_A5, PAT_A5);
        @(negedge clock);
        check_out("stream_idle_hold2", 1'b0, PAT_A5, PAT_A5);
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, RAMP, RAMP);
        @(negedge clock);
        check_out("pre_reset", 1'b1, RAMP_FWD, RAMP_INV);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check_out("async_reset", 1'b0, '0, '0);
        @(negedge clock);
        check_out("reset_mid_held", 1'b0, '0, '0);
        reset_n = 1'b1;
        drive(1'b0, '0, '0);
        @(negedge clock);
        check_out("after_release", 1'b0, '0, '0);
        drive(1'b1, FIPS_IN, FIPS_OUT);
        @(negedge clock);
        check_out("first_after_reset", 1'b1, FIPS_OUT, FIPS_IN);
        drive(1'b0, '0, '0);
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_fips_fwd();
        test_ramp();
        test_inv_fips();
        test_round_trip();
        test_back_to_back();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
